eth_rx_hdr_parser: RTL
======================

ETH_RX_HDR_PARSER -- requirements
Module: eth_rx_hdr_parser

Interface
REQ-001 The block SHALL have parameter ADDR_BUFFER_DEPTH, default 12, the number of leading header bytes captured (6 dst MAC + 6 src MAC).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2048, the maximum legal frame length in bytes.
REQ-003 The block SHALL have parameter PORT_ID, default 4'd0, the ingress port number reported in every descriptor.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  ingress frame byte.
REQ-007 rx_valid  input  1  rx_data valid; byte accepted when rx_valid && rx_ready.
REQ-008 rx_sof  input  1  accepted byte is first of frame.
REQ-009 rx_eof  input  1  accepted byte is last of frame (last FCS byte).
REQ-010 rx_ready  output  1  parser can accept a byte.
REQ-011 hdr_valid  output  1  descriptor available to the MAC-learn/lookup stage.
REQ-012 hdr_ready  input  1  downstream accepts descriptor; transfer when hdr_valid && hdr_ready.
REQ-013 hdr_dst_mac  output  48  destination MAC, first received byte in bits [47:40].
REQ-014 hdr_src_mac  output  48  source MAC, byte 7 of frame in bits [47:40].
REQ-015 hdr_port  output  4  PORT_ID.
REQ-016 hdr_len  output  12  frame byte count including FCS, saturating at 4095.
REQ-017 hdr_err  output  1  frame failed FCS or hdr_len > FIFO_DEPTH.
REQ-018 drop_cnt  output  16  count of frames discarded without descriptor, saturating at 65535.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR, PAYLOAD, HOLD.
REQ-020 IDLE: accepted byte with rx_sof SHALL start a frame (count=1, byte stored at header index 0) and go to ADDR; accepted bytes without rx_sof SHALL be ignored.
REQ-021 ADDR: each accepted byte SHALL be stored at the next header index; after byte ADDR_BUFFER_DEPTH is stored, go to PAYLOAD.
REQ-022 PAYLOAD: accepted bytes SHALL only increment count and update CRC.
REQ-023 Accepted byte with rx_eof in PAYLOAD, or as byte 12 in ADDR, SHALL latch descriptor fields and go to HOLD; hdr_valid SHALL assert the cycle after that byte is accepted.
REQ-024 rx_eof with fewer than ADDR_BUFFER_DEPTH bytes received (runt, incl. rx_sof && rx_eof same byte) SHALL drop the frame, increment drop_cnt, return to IDLE, no descriptor.
REQ-025 rx_sof on an accepted byte in ADDR or PAYLOAD SHALL abort the current frame (drop_cnt+1) and restart capture with that byte as byte 1.
REQ-026 rx_ready SHALL be 1 in IDLE, ADDR, PAYLOAD and 0 in HOLD.
REQ-027 HOLD: all hdr_* outputs SHALL stay stable while hdr_valid && !hdr_ready; on handshake go to IDLE, hdr_valid deasserts next cycle.
REQ-028 hdr_valid SHALL never depend combinationally on hdr_ready.
REQ-029 Byte counter SHALL saturate at 4095; hdr_err SHALL be 1 when hdr_len > FIFO_DEPTH.
REQ-030 Throughput: one byte per cycle while rx_ready=1; one idle input cycle (HOLD) per frame minimum.

Reset
REQ-031 On rst: FSM=IDLE, rx_ready=1 after release (0 while rst asserted), hdr_valid=0, hdr_dst_mac=0, hdr_src_mac=0, hdr_port=PORT_ID, hdr_len=0, hdr_err=0, drop_cnt=0, CRC=32'hFFFFFFFF.
REQ-032 rst asserted mid-frame or in HOLD SHALL discard the frame/descriptor without incrementing drop_cnt.

Configuration
REQ-033 With macro ETH_RX_FCS_CHECK_EN defined: reflected CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reinit at sof) SHALL run over all bytes incl. FCS; FCS fails unless residue == 32'hDEBB20E3, contributing to hdr_err.
REQ-034 Without ETH_RX_FCS_CHECK_EN: no CRC logic SHALL be synthesized; hdr_err reflects only oversize.

Verification
REQ-035 64-byte frame, dst 01:02:03:04:05:06, src 0A:0B:0C:0D:0E:0F, valid FCS, hdr_ready=1 -> one descriptor, hdr_dst_mac=48'h010203040506, hdr_src_mac=48'h0A0B0C0D0E0F, hdr_len=64, hdr_err=0, hdr_valid one cycle.
REQ-036 Same frame with last FCS byte inverted, FCS_EN defined -> hdr_err=1; undefined -> hdr_err=0.
REQ-037 8-byte frame (sof..eof) -> no hdr_valid, drop_cnt=1; then 1-byte sof&&eof -> drop_cnt=2.
REQ-038 hdr_ready held 0 for 10 cycles after hdr_valid -> fields stable, rx_ready=0 throughout; handshake on cycle 11 -> IDLE, rx_ready=1 next cycle.
REQ-039 2100-byte frame -> hdr_len=2100, hdr_err=1; 5000-byte frame -> hdr_len=4095, hdr_err=1.
REQ-040 rx_sof at byte 30 of a frame, then 64-byte frame completes -> drop_cnt+1, descriptor for second frame with hdr_len=64.

Source files
------------

// File: rtl/eth_rx_hdr_parser.sv
// Ingress header parser: captures dst/src MAC, length and error status of each frame
// into a held descriptor. Define ETH_RX_FCS_CHECK_EN to add the CRC-32 FCS check.
`timescale 1ns/1ps
module eth_rx_hdr_parser #(
    parameter int unsigned ADDR_BUFFER_DEPTH = 12,
    parameter int unsigned FIFO_DEPTH        = 2048,
    parameter logic [3:0]  PORT_ID           = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    output logic        rx_ready,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [47:0] hdr_dst_mac,
    output logic [47:0] hdr_src_mac,
    output logic [3:0]  hdr_port,
    output logic [11:0] hdr_len,
    output logic        hdr_err,
    output logic [15:0] drop_cnt
);
    localparam int unsigned HW        = ADDR_BUFFER_DEPTH * 8;
    localparam logic [11:0] HDR_BYTES = 12'(ADDR_BUFFER_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADDR    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [11:0]   cnt_q, cnt_d, cnt_inc;
    logic [HW-1:0] addr_q, addr_d, addr_shift;
    logic [47:0]   dst_q, dst_d, src_q, src_d;
    logic [11:0]   len_q, len_d;
    logic          err_q, err_d;
    logic [15:0]   drop_q, drop_d;
    logic [16:0]   drop_sum;
    logic [1:0]    drop_inc;
    logic          accept, oversize, fcs_bad;

    assign rx_ready   = !rst && (state_q != S_HOLD);
    assign accept     = rx_valid && rx_ready;
    assign hdr_valid  = (state_q == S_HOLD);
    assign cnt_inc    = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
    assign oversize   = 32'(cnt_inc) > FIFO_DEPTH;
    // Header bytes are shifted in, so the first byte ends up in the top bits.
    assign addr_shift = {addr_q[HW-9:0], rx_data};

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int unsigned b = 0; b < 8; b++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (accept && (rx_sof || state_q != S_IDLE))
            crc_d = crc_byte(rx_sof ? '1 : crc_q, rx_data);
    end

    assign fcs_bad = (crc_d != 32'hDEBB20E3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '1;
        else     crc_q <= crc_d;
    end
`else
    assign fcs_bad = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        dst_d    = dst_q;
        src_d    = src_q;
        len_d    = len_q;
        err_d    = err_q;
        drop_inc = '0;
        case (state_q)
            S_IDLE: begin
                if (accept && rx_sof) begin
                    cnt_d  = 12'd1;
                    addr_d = addr_shift;
                    if (rx_eof) drop_inc = 2'd1;
                    else        state_d  = S_ADDR;
                end
            end
            S_ADDR, S_PAYLOAD: begin
                if (accept) begin
                    if (rx_sof) begin
                        // Abort the frame in flight; a sof+eof byte is itself a runt.
                        cnt_d    = 12'd1;
                        addr_d   = addr_shift;
                        drop_inc = rx_eof ? 2'd2 : 2'd1;
                        state_d  = rx_eof ? S_IDLE : S_ADDR;
                    end else begin
                        cnt_d = cnt_inc;
                        if (state_q == S_ADDR) addr_d = addr_shift;
                        if (rx_eof) begin
                            if (state_q == S_ADDR && cnt_inc < HDR_BYTES) begin
                                drop_inc = 2'd1;
                                state_d  = S_IDLE;
                            end else begin
                                dst_d   = addr_d[HW-1 -: 48];
                                src_d   = addr_d[HW-49 -: 48];
                                len_d   = cnt_inc;
                                err_d   = oversize || fcs_bad;
                                state_d = S_HOLD;
                            end
                        end else if (state_q == S_ADDR && cnt_inc == HDR_BYTES) begin
                            state_d = S_PAYLOAD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (hdr_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        drop_sum = {1'b0, drop_q} + 17'(drop_inc);
        drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            len_q   <= len_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    assign hdr_dst_mac = dst_q;
    assign hdr_src_mac = src_q;
    assign hdr_port    = PORT_ID;
    assign hdr_len     = len_q;
    assign hdr_err     = err_q;
    assign drop_cnt    = drop_q;

endmodule
